// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32M divider encodings and defaults
package rv_pkg;

  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // op[0] clear selects the signed variants, op[1] set selects the remainder
  function automatic logic op_is_signed(input logic [1:0] op);
    return !op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// rtl/div_unit_step.sv - one combinational restoring-division iteration
module div_step
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic [DATA_WIDTH-1:0] quo,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic [DATA_WIDTH-1:0] quo_next
);

  logic [DATA_WIDTH:0] shifted;
  logic                fits;

  // The compare uses one extra bit; the subtraction result always fits in DATA_WIDTH.
  always_comb begin
    shifted  = {rem, quo[DATA_WIDTH-1]};
    fits     = (shifted >= {1'b0, divisor});
    rem_next = fits ? (shifted[DATA_WIDTH-1:0] - divisor) : shifted[DATA_WIDTH-1:0];
    quo_next = {quo[DATA_WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 RV32M divider with pipeline hold
module div_unit
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  flush,
  output logic                  hold,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_INIT = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(1);

  div_state_e            state, state_nxt;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] rem_q, rem_nxt, quo_q, quo_nxt, dvsr_q, dvsr_nxt;
  logic [DATA_WIDTH-1:0] result_nxt;
  logic                  is_rem_q, is_rem_nxt, neg_quo_q, neg_quo_nxt, neg_rem_q, neg_rem_nxt;

  logic                  in_signed, b_zero, ovf;
  logic [DATA_WIDTH-1:0] a_abs, b_abs;
  logic [DATA_WIDTH-1:0] step_rem, step_quo, quo_fix, rem_fix;

  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvsr_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_comb begin
    in_signed = op_is_signed(op);
    a_abs     = (in_signed && a[DATA_WIDTH-1]) ? -a : a;
    b_abs     = (in_signed && b[DATA_WIDTH-1]) ? -b : b;
    b_zero    = (b == '0);
    ovf       = in_signed && (a == MIN_NEG) && (b == ALL_ONES);
    quo_fix   = neg_quo_q ? -step_quo : step_quo;
    rem_fix   = neg_rem_q ? -step_rem : step_rem;
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rem_nxt     = rem_q;
    quo_nxt     = quo_q;
    dvsr_nxt    = dvsr_q;
    is_rem_nxt  = is_rem_q;
    neg_quo_nxt = neg_quo_q;
    neg_rem_nxt = neg_rem_q;
    result_nxt  = result;
    hold        = 1'b0;
    done        = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (start) begin
          hold        = 1'b1;
          is_rem_nxt  = op_is_rem(op);
          neg_quo_nxt = in_signed && (a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1]);
          neg_rem_nxt = in_signed && a[DATA_WIDTH-1];
          dvsr_nxt    = b_abs;
          quo_nxt     = a_abs;
          rem_nxt     = '0;
          cnt_nxt     = CNT_INIT;
          if (b_zero) begin
            state_nxt  = DIV_DONE;
            result_nxt = op_is_rem(op) ? a : ALL_ONES;
          end else if (ovf) begin
            state_nxt  = DIV_DONE;
            result_nxt = op_is_rem(op) ? '0 : MIN_NEG;
          end else begin
            state_nxt = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        hold    = 1'b1;
        rem_nxt = step_rem;
        quo_nxt = step_quo;
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt  = DIV_DONE;
          result_nxt = is_rem_q ? rem_fix : quo_fix;
        end
      end
      DIV_DONE: begin
        done      = 1'b1;
        state_nxt = DIV_IDLE;
      end
      default: state_nxt = DIV_IDLE;
    endcase
    // A killed op leaves the previously delivered result visible.
    if (flush) begin
      hold       = 1'b0;
      done       = 1'b0;
      state_nxt  = DIV_IDLE;
      result_nxt = result;
    end
    if (!rst_n) begin
      hold = 1'b0;
      done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DIV_IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result    <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rem_q     <= rem_nxt;
      quo_q     <= quo_nxt;
      dvsr_q    <= dvsr_nxt;
      is_rem_q  <= is_rem_nxt;
      neg_quo_q <= neg_quo_nxt;
      neg_rem_q <= neg_rem_nxt;
      result    <= result_nxt;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        hold;
  logic        done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  div_unit #(.DATA_WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .hold   (hold),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          holds;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    logic [31:0] q, r;
    sx = $signed(x);
    sy = $signed(y);
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (!o[0]) begin
      q = 32'(sx / sy);
      r = 32'(sx % sy);
    end else begin
      q = x / y;
      r = x % y;
    end
    return o[1] ? r : q;
  endfunction

  function automatic int ref_holds(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (y == 32'd0) return 1;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Leaves the bench at the DONE cycle (negedge + 1) with start still high.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int holds, output bit got,
                        output logic hold_at_done);
    holds = 0;
    got = 1'b0;
    res = '0;
    hold_at_done = 1'b1;
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (done) begin
        got = 1'b1;
        res = result;
        hold_at_done = hold;
        break;
      end
      if (hold) holds++;
      @(negedge clk);
      a = $urandom;
      b = $urandom;
    end
  endtask

  task automatic check_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int exp_holds);
    logic [31:0] res;
    int holds;
    bit got;
    logic hd;
    run_op(o, x, y, res, holds, got, hd);
    check({name, "_done_seen"}, 32'(got), 32'd1);
    check({name, "_result"}, res, exp);
    check({name, "_holds"}, 32'(holds), 32'(exp_holds));
    check({name, "_hold_at_done"}, 32'(hd), 32'd0);
  endtask

  task automatic finish_op(input string name);
    @(negedge clk);
    start = 1'b0;
    #1;
    check({name, "_done_single"}, 32'(done), 32'd0);
  endtask

  task automatic quiet_cycles(input string name, input int n, input logic [31:0] exp_result);
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      if (done) pulses++;
    end
    check({name, "_no_done"}, 32'(pulses), 32'd0);
    check({name, "_result_kept"}, result, exp_result);
  endtask

  initial begin
    vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[3]  = '{2'b11, 32'hFFFF_FFF9,  32'd2,          32'd1,          33};
    vecs[4]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[5]  = '{2'b10, 32'd5,          32'd0,          32'd5,          1};
    vecs[6]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[7]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[8]  = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
    vecs[9]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
    vecs[10] = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          33};
    vecs[11] = '{2'b10, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  33};
    vecs[12] = '{2'b00, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          33};
    vecs[13] = '{2'b11, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  1};
    vecs[14] = '{2'b01, 32'd0,          32'd5,          32'd0,          33};

    rst_n = 1'b0;
    start = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    flush = 1'b0;
    #1;
    check("reset_hold", 32'(hold), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].holds);
      finish_op($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      int sel;
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: rb = 32'd0;
        1: begin
          rb = 32'hFFFF_FFFF;
          if ($urandom_range(0, 1) == 1) ra = 32'h8000_0000;
        end
        2: rb = 32'($urandom_range(1, 16));
        3: rb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      check_op($sformatf("rand%0d_op%0d_a%08h_b%08h", i, ro, ra, rb), ro, ra, rb,
               ref_div(ro, ra, rb), ref_holds(ro, ra, rb));
      finish_op($sformatf("rand%0d", i));
    end

    // Flush on the tenth CALC cycle: prior result must survive.
    check_op("pre_flush", 2'b01, 32'd100, 32'd7, 32'd14, 33);
    finish_op("pre_flush");
    @(negedge clk);
    start = 1'b1;
    op = 2'b01;
    a = 32'd1000;
    b = 32'd3;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_hold", 32'(hold), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    quiet_cycles("after_flush", 40, 32'd14);
    check_op("post_flush", 2'b01, 32'd1000, 32'd3, 32'd333, 33);
    finish_op("post_flush");

    // Reset on the fifth CALC cycle.
    @(negedge clk);
    start = 1'b1;
    op = 2'b00;
    a = 32'd12345;
    b = 32'd17;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_hold", 32'(hold), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    quiet_cycles("after_reset", 40, 32'd0);

    // Back-to-back: second op starts the cycle right after DONE.
    check_op("b2b_first", 2'b01, 32'd20, 32'd3, 32'd6, 33);
    check_op("b2b_second", 2'b11, 32'd20, 32'd3, 32'd2, 33);
    finish_op("b2b_second");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 integer divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting beside the ALU in EX.
- Drives the pipeline hold signal: while busy it raises `hold`, which feeds the active-low `en` of the IF/ID/EX pipeline registers (en=1 → register holds).
- Releases the pipeline for exactly one cycle with the result valid.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  EX holds a divide op; stays high while the instruction sits in EX.
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- a  in  DATA_WIDTH  dividend.
- b  in  DATA_WIDTH  divisor.
- flush  in  1  kill current op (branch mispredict/trap).
- hold  out  1  1 = freeze pipeline registers (wire to their active-low en).
- done  out  1  result valid this cycle.
- result  out  DATA_WIDTH  quotient or remainder per op.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, counter=0, all internal regs 0; hold=0, done=0, result=0. Reset mid-operation aborts with no output.
- States: IDLE, CALC, DONE.
- hold (combinational) = !flush & ((state==IDLE & start) | state==CALC). hold=0 in DONE.
- IDLE, start=1, no flush:
  - Latch op and signs.
  - Load |a| and |b| (signed ops) or raw a and b (unsigned ops).
  - remainder=0; counter=DATA_WIDTH.
- IDLE special cases go straight to DONE (1 hold cycle):
  - b==0: quotient=all ones; remainder=a.
  - Signed overflow (op DIV/REM, a=0x80000000, b=0xFFFFFFFF): quotient=0x80000000; remainder=0.
  - Otherwise go to CALC.
- CALC, one restoring step per cycle:
  - Shift {rem,quo} left by 1.
  - If rem ≥ divisor: rem -= divisor, quo[0]=1.
  - counter-1. When counter reaches 0 after the step → DONE.
  - Arithmetic in DATA_WIDTH+1 bits to avoid compare overflow.
- Latency: normal op holds 1+DATA_WIDTH cycles (33); special ops hold 1 cycle; DONE cycle always follows.
- DONE:
  - done=1, result registered on DONE entry; result holds its value until next DONE.
  - Sign fix-up for signed ops: quotient negated if sign(a)≠sign(b); remainder takes sign of a.
  - start is ignored in DONE (the same instruction still in EX). Next state IDLE.
  - A new divide arriving the following cycle starts normally (back-to-back supported).
- flush:
  - In any state, forces hold=0 and done=0 combinationally; next state IDLE.
  - Partial result discarded; result register unchanged.
- start deasserting during CALC (should not occur while held) is ignored; completion proceeds.
- Divisor/dividend inputs are sampled only on IDLE→CALC/DONE; later changes have no effect.

Decomposition:
- Shared package (rv_pkg):
  - Op encodings DIV_OP_DIV/DIVU/REM/REMU.
  - DATA_WIDTH default.
  - State encoding constants DIV_IDLE/DIV_CALC/DIV_DONE.
- One natural sub-module: div_step. Purely combinational single restoring iteration: {rem,quo},divisor → next {rem,quo}.
- The FSM, counter and sign handling stay in div_unit.

Test Plan:
- DIVU a=100, b=7 → hold high 33 cycles, then done=1 with result=14 (0x0000000E) for one cycle; hold=0 that cycle.
- DIV a=-7 (0xFFFFFFF9), b=2 → result 0xFFFFFFFD (-3). REM same operands → 0xFFFFFFFF (-1). REMU a=0xFFFFFFF9, b=2 → 1.
- DIV a=5, b=0 → hold 1 cycle, next cycle done=1, result 0xFFFFFFFF. REM a=5, b=0 → result 5.
- DIV a=0x80000000, b=0xFFFFFFFF → 1-cycle hold, result 0x80000000. REM same operands → 0.
- Abort cases:
  - flush on CALC cycle 10 → hold=0 same cycle; IDLE next cycle; no done pulse; result keeps its previous value.
  - rst_n low on CALC cycle 5 → hold=0, done=0, result=0 immediately.
- Back-to-back: DIVU 20/3 then, the cycle after DONE, REMU 20/3 → first done result 6, second done result 2; 33 hold cycles each, a single non-hold cycle between them.
